vector_sequencer: RTL and testbench
===================================

// Module: vector_sequencer
// PURPOSE
//  Pattern source for the tester pin channels. Stores a vector table (per-pin data plus 2-bit force format).
//  Replays the table one vector per tester period, generating the shared CYCLE strobe and per-pin D/FF.
//  Sits directly upstream of the per-pin FF_REG force-format registers: CYCLE, D[i], FF[2i+1:2i] feed pin i.
// PARAMETERS
//  NPINS   8  number of pin channels driven
//  ADDR_W  6  vector table address width (depth = 2**ADDR_W)
//  PER_W   8  width of period/edge timing fields, in CLK cycles
// PORTS
//  CLK        in   1              system clock; all logic on posedge CLK
//  RST        in   1              synchronous, active-high reset
//  WR_EN      in   1              vector table write strobe (ignored while BUSY)
//  WR_ADDR    in   ADDR_W         write address
//  WR_DATA    in   3*NPINS        {FF[2*NPINS-1:0], D[NPINS-1:0]} for one vector
//  START      in   1              pulse: begin replay at address 0 (ignored unless IDLE or DONE)
//  STOP       in   1              pulse: end replay after the current period completes
//  LAST_ADDR  in   ADDR_W         address of final vector in the pattern
//  PERIOD     in   PER_W          tester period in CLK cycles, sampled at START
//  T_LEAD     in   PER_W          CLK offset of CYCLE rising (leading) edge, sampled at START
//  T_TRAIL    in   PER_W          CLK offset of CYCLE falling (trailing) edge, sampled at START
//  CYCLE      out  1              tester strobe to all FF_REG instances
//  D          out  NPINS          per-pin drive data
//  FF         out  2*NPINS        per-pin force format (R0=00, R1=01, DNRZ_L=10, DNRZ_T=11)
//  VEC_ADDR   out  ADDR_W         address of vector currently driven
//  BUSY       out  1              high in LOAD and RUN
//  DONE       out  1              high in DONE until next START
//  CFG_ERR    out  1              high for one cycle when START is rejected for bad timing
// BEHAVIOUR
//  - Reset: state IDLE; CYCLE=0, D=0, FF=0 (R0), VEC_ADDR=0, BUSY=0, DONE=0, CFG_ERR=0; table contents not cleared.
//  - Timing is legal iff 1 <= T_LEAD < T_TRAIL < PERIOD. START with illegal timing leaves state unchanged and pulses CFG_ERR.
//  - FSM: IDLE -START-> LOAD -> RUN -(last period done | STOP seen)-> DONE -START-> LOAD.
//  - LOAD (1 cycle): synchronous table read of address 0; latches PERIOD/T_LEAD/T_TRAIL.
//  - RUN: phase counter ph runs 0..PERIOD-1 and wraps.
//    - At ph==0, D/FF/VEC_ADDR update to the prefetched vector; they are stable for the whole period.
//    - CYCLE is registered: CYCLE=1 iff T_LEAD <= ph < T_TRAIL.
//    - Next vector is read during ph==1, so its data is ready well before the next ph==0.
//  - Latency: START at edge k -> LOAD at k+1 -> first vector on D/FF and ph=0 at k+2 -> CYCLE rises at k+2+T_LEAD.
//  - End of pattern: when the period with VEC_ADDR==LAST_ADDR completes, go to DONE.
//    - DONE: CYCLE=0, D/FF hold the last vector, BUSY=0, DONE=1.
//  - STOP during RUN is registered as pending; the current period completes (CYCLE edges intact), then DONE.
//    - STOP and end of pattern in the same period: DONE once, no difference.
//  - START and STOP in the same cycle while IDLE: START wins.
//  - Address counter is ADDR_W bits. LAST_ADDR = 2**ADDR_W-1 is legal, with no overflow past it.
//  - WR_EN during BUSY is dropped; a write to the address currently being read in LOAD cannot occur.
//  - RST asserted mid-RUN: outputs return to reset values on that edge; no partial period completes.
// CONFIGURATION
//  - Macro PATTERN_LOOP_EN compiled in:
//    - Adds input LOOP_ADDR[ADDR_W-1:0] and input LOOP_ON[0].
//    - With LOOP_ON=1, finishing LAST_ADDR jumps to LOOP_ADDR (no gap period) and replay continues until STOP.
//    - LOOP_ADDR > LAST_ADDR counts as illegal timing and raises CFG_ERR at START.
//  - Without the macro: ports are absent and replay always ends at LAST_ADDR.
// STRUCTURE
//  - Shared package tester_pkg holds:
//    - FF encoding constants R0/R1/DNRZ_L/DNRZ_T;
//    - the sequencer state encoding (IDLE/LOAD/RUN/DONE);
//    - the vector word layout helpers (D field, FF field offsets).
//  - Sub-module vec_mem: single-port-write / single-port-read synchronous RAM, depth 2**ADDR_W, width 3*NPINS, no reset.
// TESTING
//  - PERIOD=10, T_LEAD=2, T_TRAIL=6, LAST_ADDR=3, vectors D=1,2,4,8.
//    -> 4 periods; CYCLE high ph 2..5; D changes only at ph==0; DONE after 40 CLKs of RUN.
//  - START with T_LEAD=0, or with T_TRAIL=PERIOD.
//    -> CFG_ERR pulse for 1 cycle, state stays IDLE, CYCLE stays 0.
//  - STOP pulsed at ph==3 of vector 1 (LAST_ADDR=7).
//    -> vector 1 period completes with CYCLE falling at T_TRAIL, DONE=1, VEC_ADDR=1.
//  - RST pulsed at ph==4 while CYCLE=1.
//    -> next edge: CYCLE=0, D=0, FF=0, BUSY=0; a later START replays from address 0.
//  - WR_EN to addr 2 during RUN with new data.
//    -> replay still drives the old addr-2 contents; the write takes effect only when issued while IDLE.
//  - PATTERN_LOOP_EN build, LOOP_ON=1, LOOP_ADDR=1, LAST_ADDR=2.
//    -> VEC_ADDR sequence 0,1,2,1,2,1,... until STOP.

Source files
------------

// File: rtl/tester_pkg.sv
// -----------------------------------------------------------------------------
// tester_pkg
// Shared definitions for the tester pattern path:
//   - force-format encodings carried on FF[2i+1:2i] for each pin
//   - sequencer state encoding
//   - vector word layout: {FF[2*NPINS-1:0], D[NPINS-1:0]}
// No ports (package).
// -----------------------------------------------------------------------------
package tester_pkg;

    // Per-pin force formats
    localparam logic [1:0] FF_R0     = 2'b00;
    localparam logic [1:0] FF_R1     = 2'b01;
    localparam logic [1:0] FF_DNRZ_L = 2'b10;
    localparam logic [1:0] FF_DNRZ_T = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    // Vector word layout: D occupies the low NPINS bits, FF sits directly above.
    localparam int unsigned VEC_D_LSB = 0;

    function automatic int unsigned vec_ff_lsb(input int unsigned npins);
        return npins;
    endfunction

    function automatic int unsigned vec_width(input int unsigned npins);
        return 3 * npins;
    endfunction

endpackage

// File: rtl/vector_sequencer_vec_mem.sv
// -----------------------------------------------------------------------------
// vec_mem
// Vector table storage: one synchronous write port, one synchronous read port,
// depth 2**ADDR_W, no reset (contents survive RST).
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write word
//   i_rd_en    read strobe; o_rd_data holds its value when low
//   i_rd_addr  read address
//   o_rd_data  registered read word
// -----------------------------------------------------------------------------
module vec_mem #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WIDTH  = 24
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [2**ADDR_W];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vector_sequencer.sv
// -----------------------------------------------------------------------------
// vector_sequencer
// Pattern source for the tester pin channels. Stores a vector table and
// replays it one vector per tester period, producing the shared CYCLE strobe
// and per-pin D / FF for the downstream FF_REG force-format registers.
//
// Optional feature: define PATTERN_LOOP_EN to add LOOP_ADDR / LOOP_ON, which
// make replay jump from LAST_ADDR back to LOOP_ADDR until STOP.
//
// Ports:
//   CLK        system clock
//   RST        synchronous active-high reset
//   WR_EN      table write strobe (dropped while BUSY)
//   WR_ADDR    table write address
//   WR_DATA    {FF, D} vector word
//   START      begin replay at address 0 (IDLE or DONE only)
//   STOP       end replay once the current period completes
//   LAST_ADDR  final vector address, sampled at START
//   PERIOD     tester period in CLKs, sampled at START
//   T_LEAD     CYCLE rising offset, sampled at START
//   T_TRAIL    CYCLE falling offset, sampled at START
//   LOOP_ADDR  (PATTERN_LOOP_EN) loop-back address, sampled at START
//   LOOP_ON    (PATTERN_LOOP_EN) enable loop-back, sampled at START
//   CYCLE      tester strobe
//   D          per-pin drive data
//   FF         per-pin force format
//   VEC_ADDR   address of vector on D/FF
//   BUSY       high in LOAD and RUN
//   DONE       high in DONE
//   CFG_ERR    one-cycle pulse when START is rejected
// -----------------------------------------------------------------------------
module vector_sequencer
    import tester_pkg::*;
#(
    parameter int unsigned NPINS  = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned PER_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [ADDR_W-1:0]     WR_ADDR,
    input  logic [3*NPINS-1:0]    WR_DATA,
    input  logic                  START,
    input  logic                  STOP,
    input  logic [ADDR_W-1:0]     LAST_ADDR,
    input  logic [PER_W-1:0]      PERIOD,
    input  logic [PER_W-1:0]      T_LEAD,
    input  logic [PER_W-1:0]      T_TRAIL,
`ifdef PATTERN_LOOP_EN
    input  logic [ADDR_W-1:0]     LOOP_ADDR,
    input  logic                  LOOP_ON,
`endif
    output logic                  CYCLE,
    output logic [NPINS-1:0]      D,
    output logic [2*NPINS-1:0]    FF,
    output logic [ADDR_W-1:0]     VEC_ADDR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  CFG_ERR
);

    localparam int unsigned VW     = vec_width(NPINS);
    localparam int unsigned FF_LSB = vec_ff_lsb(NPINS);

    seq_state_t         r_state;
    logic [PER_W-1:0]   r_ph;
    logic [PER_W-1:0]   r_period;
    logic [PER_W-1:0]   r_t_lead;
    logic [PER_W-1:0]   r_t_trail;
    logic [ADDR_W-1:0]  r_last_addr;
    logic [ADDR_W-1:0]  r_vec_addr;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_first;
    logic               r_stop_pend;
    logic               r_cycle;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_err;
    logic [NPINS-1:0]   r_d;
    logic [2*NPINS-1:0] r_ff;

    logic               w_start_req;
    logic               w_timing_ok;
    logic               w_loop_ok;
    logic               w_cfg_ok;
    logic               w_loop_on;
    logic [ADDR_W-1:0]  w_loop_addr;
    logic               w_at_last;
    logic               w_end_of_pattern;
    logic               w_stop_seen;
    logic               w_ph_end;
    logic [PER_W-1:0]   w_ph_inc;
    logic               w_rd_en;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ADDR_W-1:0]  w_next_addr;
    logic               w_wr_en;
    logic [VW-1:0]      w_rd_data;

`ifdef PATTERN_LOOP_EN
    logic               r_loop_on;
    logic [ADDR_W-1:0]  r_loop_addr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_loop_on   <= 1'b0;
            r_loop_addr <= '0;
        end else if (w_start_req && w_cfg_ok) begin
            r_loop_on   <= LOOP_ON;
            r_loop_addr <= LOOP_ADDR;
        end
    end

    assign w_loop_ok   = !LOOP_ON || (LOOP_ADDR <= LAST_ADDR);
    assign w_loop_on   = r_loop_on;
    assign w_loop_addr = r_loop_addr;
`else
    assign w_loop_ok   = 1'b1;
    assign w_loop_on   = 1'b0;
    assign w_loop_addr = '0;
`endif

    assign w_start_req = START && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_timing_ok = (T_LEAD != '0) && (T_LEAD < T_TRAIL) && (T_TRAIL < PERIOD);
    assign w_cfg_ok    = w_timing_ok && w_loop_ok;

    assign w_at_last        = (r_vec_addr == r_last_addr);
    assign w_end_of_pattern = w_at_last && !w_loop_on;
    // STOP arriving on the final phase still counts for the period ending now.
    assign w_stop_seen      = r_stop_pend || STOP;

    assign w_ph_end = (r_ph == r_period - 1'b1);
    assign w_ph_inc = r_ph + 1'b1;

    // Past the last address without looping the increment wraps; that read is
    // never used because the sequencer leaves RUN at the end of this period.
    assign w_next_addr = (w_loop_on && w_at_last) ? w_loop_addr : r_vec_addr + 1'b1;

    // Prefetch: address 0 in LOAD, next vector during ph==1 of each period.
    assign w_rd_en   = (r_state == S_LOAD) ||
                       ((r_state == S_RUN) && !r_first && (r_ph == PER_W'(1)));
    assign w_rd_addr = (r_state == S_LOAD) ? '0 : w_next_addr;

    assign w_wr_en = WR_EN && !r_busy;

    vec_mem #(
        .ADDR_W (ADDR_W),
        .WIDTH  (VW)
    ) u_vec_mem (
        .i_clk     (CLK),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (WR_ADDR),
        .i_wr_data (WR_DATA),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_ph        <= '0;
            r_period    <= '0;
            r_t_lead    <= '0;
            r_t_trail   <= '0;
            r_last_addr <= '0;
            r_vec_addr  <= '0;
            r_rd_addr   <= '0;
            r_first     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_cycle     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_d         <= '0;
            r_ff        <= {NPINS{FF_R0}};
        end else begin
            r_cfg_err <= 1'b0;
            if (w_rd_en) begin
                r_rd_addr <= w_rd_addr;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_req) begin
                        if (w_cfg_ok) begin
                            r_state     <= S_LOAD;
                            r_period    <= PERIOD;
                            r_t_lead    <= T_LEAD;
                            r_t_trail   <= T_TRAIL;
                            r_last_addr <= LAST_ADDR;
                            r_stop_pend <= 1'b0;
                            r_busy      <= 1'b1;
                            r_done      <= 1'b0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    // Park the phase on its last value so the next edge wraps
                    // to ph==0 and presents vector 0, without an end check.
                    r_state <= S_RUN;
                    r_ph    <= r_period - 1'b1;
                    r_first <= 1'b1;
                    if (STOP) begin
                        r_stop_pend <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (STOP) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_ph_end) begin
                        if (!r_first && (w_stop_seen || w_end_of_pattern)) begin
                            r_state <= S_DONE;
                            r_cycle <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_first    <= 1'b0;
                            r_ph       <= '0;
                            r_cycle    <= 1'b0;
                            r_vec_addr <= r_rd_addr;
                            r_d        <= w_rd_data[VEC_D_LSB +: NPINS];
                            r_ff       <= w_rd_data[FF_LSB +: 2*NPINS];
                        end
                    end else begin
                        r_ph    <= w_ph_inc;
                        r_cycle <= (w_ph_inc >= r_t_lead) && (w_ph_inc < r_t_trail);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CYCLE    = r_cycle;
    assign D        = r_d;
    assign FF       = r_ff;
    assign VEC_ADDR = r_vec_addr;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign CFG_ERR  = r_cfg_err;

endmodule

// File: tb/tb_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_sequencer
// Directed bench for vector_sequencer: configuration-rejection vectors from a
// table, plus hand-written replay sequences checked cycle by cycle against a
// bench-side copy of the vector table. Define PATTERN_LOOP_EN to also cover
// the loop-back feature.
// -----------------------------------------------------------------------------
module tb_vector_sequencer;

    localparam int NPINS  = 8;
    localparam int ADDR_W = 6;
    localparam int PER_W  = 8;
    localparam int VW     = 3 * NPINS;

    logic                CLK = 1'b0;
    logic                RST;
    logic                WR_EN;
    logic [ADDR_W-1:0]   WR_ADDR;
    logic [VW-1:0]       WR_DATA;
    logic                START;
    logic                STOP;
    logic [ADDR_W-1:0]   LAST_ADDR;
    logic [PER_W-1:0]    PERIOD;
    logic [PER_W-1:0]    T_LEAD;
    logic [PER_W-1:0]    T_TRAIL;
`ifdef PATTERN_LOOP_EN
    logic [ADDR_W-1:0]   LOOP_ADDR;
    logic                LOOP_ON;
`endif
    logic                CYCLE;
    logic [NPINS-1:0]    D;
    logic [2*NPINS-1:0]  FF;
    logic [ADDR_W-1:0]   VEC_ADDR;
    logic                BUSY;
    logic                DONE;
    logic                CFG_ERR;

    vector_sequencer #(
        .NPINS  (NPINS),
        .ADDR_W (ADDR_W),
        .PER_W  (PER_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .START     (START),
        .STOP      (STOP),
        .LAST_ADDR (LAST_ADDR),
        .PERIOD    (PERIOD),
        .T_LEAD    (T_LEAD),
        .T_TRAIL   (T_TRAIL),
`ifdef PATTERN_LOOP_EN
        .LOOP_ADDR (LOOP_ADDR),
        .LOOP_ON   (LOOP_ON),
`endif
        .CYCLE     (CYCLE),
        .D         (D),
        .FF        (FF),
        .VEC_ADDR  (VEC_ADDR),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .CFG_ERR   (CFG_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int per;
        int lead;
        int trail;
        int exp_err;
        int exp_busy;
    } cfg_vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [VW-1:0] model_mem [64];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [VW-1:0] mk_word(input int d, input int ff);
        logic [NPINS-1:0]   dd;
        logic [2*NPINS-1:0] fv;
        dd = NPINS'(d);
        fv = (2*NPINS)'(ff);
        return {fv, dd};
    endfunction

    task automatic write_vec(input int a, input logic [VW-1:0] w);
        WR_EN   = 1'b1;
        WR_ADDR = ADDR_W'(a);
        WR_DATA = w;
        tick();
        WR_EN   = 1'b0;
        model_mem[a] = w;
    endtask

    // Replay with PERIOD=10, T_LEAD=2, T_TRAIL=6 from address 0, checked every
    // CLK. stop_n / wr_n are RUN-cycle indices at which STOP or a write to
    // address 2 is injected (-1 = never); the write must not land.
    task automatic run_pattern(input int last, input bit stop_with_start,
                               input int stop_n, input int wr_n,
                               input logic [VW-1:0] wr_word);
        int nper;
        int p;
        int ph;
        logic [VW-1:0] w;
        PERIOD    = 8'd10;
        T_LEAD    = 8'd2;
        T_TRAIL   = 8'd6;
        LAST_ADDR = ADDR_W'(last);
        START     = 1'b1;
        STOP      = stop_with_start;
        tick();
        START = 1'b0;
        STOP  = 1'b0;
        chk("load_busy", int'(BUSY), 1);
        chk("load_done_clr", int'(DONE), 0);
        chk("load_cycle", int'(CYCLE), 0);
        tick();
        chk("gap_cycle", int'(CYCLE), 0);
        nper = last + 1;
        for (int n = 0; n < nper * 10; n++) begin
            tick();
            STOP  = 1'b0;
            WR_EN = 1'b0;
            p  = n / 10;
            ph = n % 10;
            w  = model_mem[p];
            chk($sformatf("run_cycle@%0d", n), int'(CYCLE), (ph >= 2 && ph < 6) ? 1 : 0);
            chk($sformatf("run_d@%0d", n), int'(D), int'(w[NPINS-1:0]));
            if (ph == 0) begin
                chk($sformatf("run_vaddr@%0d", n), int'(VEC_ADDR), p);
                chk($sformatf("run_ff@%0d", n), int'(FF), int'(w[VW-1:NPINS]));
                chk($sformatf("run_busy@%0d", n), int'(BUSY), 1);
                chk($sformatf("run_done@%0d", n), int'(DONE), 0);
            end
            if (n == stop_n) begin
                STOP = 1'b1;
                nper = p + 1;
            end
            if (n == wr_n) begin
                WR_EN   = 1'b1;
                WR_ADDR = ADDR_W'(2);
                WR_DATA = wr_word;
            end
        end
        tick();
        w = model_mem[nper-1];
        chk("end_done", int'(DONE), 1);
        chk("end_busy", int'(BUSY), 0);
        chk("end_cycle", int'(CYCLE), 0);
        chk("end_vaddr", int'(VEC_ADDR), nper - 1);
        chk("end_d_hold", int'(D), int'(w[NPINS-1:0]));
        chk("end_ff_hold", int'(FF), int'(w[VW-1:NPINS]));
    endtask

    initial begin
        cfg_vec_t cfg_tab [6];
        logic [VW-1:0] new2;

        cfg_tab[0] = '{per: 10, lead: 0, trail: 6,  exp_err: 1, exp_busy: 0};
        cfg_tab[1] = '{per: 10, lead: 2, trail: 10, exp_err: 1, exp_busy: 0};
        cfg_tab[2] = '{per: 10, lead: 6, trail: 6,  exp_err: 1, exp_busy: 0};
        cfg_tab[3] = '{per: 10, lead: 7, trail: 3,  exp_err: 1, exp_busy: 0};
        cfg_tab[4] = '{per: 2,  lead: 1, trail: 2,  exp_err: 1, exp_busy: 0};
        cfg_tab[5] = '{per: 0,  lead: 0, trail: 0,  exp_err: 1, exp_busy: 0};

        RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        START = 1'b0; STOP = 1'b0; LAST_ADDR = '0;
        PERIOD = '0; T_LEAD = '0; T_TRAIL = '0;
`ifdef PATTERN_LOOP_EN
        LOOP_ADDR = '0; LOOP_ON = 1'b0;
`endif
        tick();
        tick();
        chk("rst_cycle", int'(CYCLE), 0);
        chk("rst_d", int'(D), 0);
        chk("rst_ff", int'(FF), 0);
        chk("rst_vaddr", int'(VEC_ADDR), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_cfgerr", int'(CFG_ERR), 0);
        RST = 1'b0;
        tick();

        for (int a = 0; a < 8; a++) begin
            write_vec(a, mk_word(1 << a, (a + 1) * 'h0F13));
        end

        // Rejected configurations: one-cycle CFG_ERR, state stays IDLE.
        for (int i = 0; i < 6; i++) begin
            PERIOD  = PER_W'(cfg_tab[i].per);
            T_LEAD  = PER_W'(cfg_tab[i].lead);
            T_TRAIL = PER_W'(cfg_tab[i].trail);
            LAST_ADDR = ADDR_W'(3);
            START = 1'b1;
            tick();
            START = 1'b0;
            chk($sformatf("cfg%0d_err", i), int'(CFG_ERR), cfg_tab[i].exp_err);
            chk($sformatf("cfg%0d_busy", i), int'(BUSY), cfg_tab[i].exp_busy);
            chk($sformatf("cfg%0d_cycle", i), int'(CYCLE), 0);
            tick();
            chk($sformatf("cfg%0d_err_clr", i), int'(CFG_ERR), 0);
            chk($sformatf("cfg%0d_idle", i), int'(BUSY), 0);
            chk($sformatf("cfg%0d_done", i), int'(DONE), 0);
        end

        // Four-vector replay; STOP alongside START in IDLE is ignored.
        run_pattern(3, 1'b1, -1, -1, '0);

        // STOP at ph==3 of vector 1 with LAST_ADDR=7.
        run_pattern(7, 1'b0, 13, -1, '0);

        // Reset mid-period while CYCLE is high.
        PERIOD = 8'd10; T_LEAD = 8'd2; T_TRAIL = 8'd6; LAST_ADDR = ADDR_W'(3);
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        for (int n = 0; n <= 4; n++) tick();
        chk("pre_rst_cycle", int'(CYCLE), 1);
        chk("pre_rst_d", int'(D), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_cycle", int'(CYCLE), 0);
        chk("mid_rst_d", int'(D), 0);
        chk("mid_rst_ff", int'(FF), 0);
        chk("mid_rst_busy", int'(BUSY), 0);
        chk("mid_rst_vaddr", int'(VEC_ADDR), 0);
        chk("mid_rst_done", int'(DONE), 0);
        tick();
        chk("post_rst_idle", int'(BUSY), 0);

        // Write to address 2 during RUN is dropped; replay restarts at 0.
        new2 = mk_word('hAA, 'hBEEF);
        run_pattern(3, 1'b0, -1, 5, new2);

        // Same write issued while not busy takes effect.
        write_vec(2, new2);
        run_pattern(3, 1'b0, -1, -1, '0);

        // Tightest legal timing, single-vector pattern.
        PERIOD = 8'd3; T_LEAD = 8'd1; T_TRAIL = 8'd2; LAST_ADDR = '0;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("min_cfgerr", int'(CFG_ERR), 0);
        chk("min_busy", int'(BUSY), 1);
        tick();
        tick();
        chk("min_ph0_cycle", int'(CYCLE), 0);
        chk("min_ph0_d", int'(D), 1);
        tick();
        chk("min_ph1_cycle", int'(CYCLE), 1);
        tick();
        chk("min_ph2_cycle", int'(CYCLE), 0);
        chk("min_ph2_busy", int'(BUSY), 1);
        tick();
        chk("min_done", int'(DONE), 1);
        chk("min_vaddr", int'(VEC_ADDR), 0);

`ifdef PATTERN_LOOP_EN
        begin
            int exp_seq [7];
            exp_seq = '{0, 1, 2, 1, 2, 1, 2};
            // LOOP_ADDR beyond LAST_ADDR is rejected.
            PERIOD = 8'd4; T_LEAD = 8'd1; T_TRAIL = 8'd2;
            LAST_ADDR = ADDR_W'(2); LOOP_ADDR = ADDR_W'(3); LOOP_ON = 1'b1;
            START = 1'b1;
            tick();
            START = 1'b0;
            chk("loop_bad_err", int'(CFG_ERR), 1);
            chk("loop_bad_busy", int'(BUSY), 0);
            LOOP_ADDR = ADDR_W'(1);
            START = 1'b1;
            tick();
            START = 1'b0;
            chk("loop_busy", int'(BUSY), 1);
            tick();
            for (int pp = 0; pp < 7; pp++) begin
                tick();
                chk($sformatf("loop_vaddr%0d", pp), int'(VEC_ADDR), exp_seq[pp]);
                if (pp < 6) begin
                    tick(); tick(); tick();
                end
            end
            STOP = 1'b1;
            tick();
            STOP = 1'b0;
            tick();
            tick();
            chk("loop_busy_last", int'(BUSY), 1);
            tick();
            chk("loop_done", int'(DONE), 1);
            chk("loop_end_vaddr", int'(VEC_ADDR), 2);
            LOOP_ON = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
